vlc_input_conditioner: RTL and testbench

Front-end stage for the vehicle lighting controller (`vlc`). Takes the three raw driver switches (turn-left, turn-right, emergency) from the dedicated inputs, then:
- synchronises and debounces each switch;
- resolves conflicting requests into one clean mode;
- generates the lamp-sequence step tick that `vlc` uses to advance its lamp patterns.

It sits between `ui_in[2:0]` and the `vlc` control inputs inside `tt_um_vlc`.

---
 rtl/vlc_input_conditioner.sv | 94 +++++++++
 tb/tb_vlc_input_conditioner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vlc_input_conditioner.sv
// Input front end for the vehicle lighting controller: synchronises and debounces
// the three driver switches, arbitrates them into one mode and paces lamp steps.
module vlc_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TICK_DIV        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic turn_left_raw,
  input  logic turn_right_raw,
  input  logic emergency_raw,
  output logic turn_left,
  output logic turn_right,
  output logic emergency,
  output logic step_tick
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  // Bit 0 = left, bit 1 = right, bit 2 = emergency throughout.
  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    stable;
  logic [CW-1:0] cnt [3];
  logic [2:0]    mode;
  logic [2:0]    mode_next;
  logic [TW-1:0] tick_cnt;

  assign raw  = {emergency_raw, turn_right_raw, turn_left_raw};
  assign mode = {emergency, turn_right, turn_left};

  // Two-flop synchroniser followed by a per-input stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Hazard wins; both turns together also mean hazard. Result is one-hot or zero.
  always_comb begin
    mode_next = 3'b000;
    if (stable[2] || (stable[0] && stable[1])) begin
      mode_next = 3'b100;
    end else if (stable[0]) begin
      mode_next = 3'b001;
    end else if (stable[1]) begin
      mode_next = 3'b010;
    end
  end

  // A mode change restarts the step period so the first step is a full period later.
  always_ff @(posedge clk) begin
    if (rst) begin
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      emergency  <= 1'b0;
      tick_cnt   <= '0;
      step_tick  <= 1'b0;
    end else begin
      {emergency, turn_right, turn_left} <= mode_next;
      if (mode_next != mode) begin
        tick_cnt  <= '0;
        step_tick <= 1'b0;
      end else if (tick_cnt == TICK_MAX) begin
        tick_cnt  <= '0;
        step_tick <= 1'b1;
      end else begin
        tick_cnt  <= tick_cnt + TW'(1);
        step_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vlc_input_conditioner.sv
// Directed bench for vlc_input_conditioner at default parameters (debounce 16, tick 4).
module tb_vlc_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic turn_left_raw;
  logic turn_right_raw;
  logic emergency_raw;
  logic turn_left;
  logic turn_right;
  logic emergency;
  logic step_tick;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        l;
    logic        r;
    logic        e;
    int unsigned cycles;
    logic [2:0]  exp_mode;  // {emergency, turn_right, turn_left}
  } vec_t;

  vec_t tbl [13];
  logic pat [5];
  logic saw;

  vlc_input_conditioner #(
    .DEBOUNCE_CYCLES(16),
    .TICK_DIV(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .turn_left_raw(turn_left_raw),
    .turn_right_raw(turn_right_raw),
    .emergency_raw(emergency_raw),
    .turn_left(turn_left),
    .turn_right(turn_right),
    .emergency(emergency),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  // Outputs must be one-hot or all zero on every cycle.
  always @(negedge clk) begin
    checks++;
    if ($countones({emergency, turn_right, turn_left}) > 1) begin
      fails++;
      $display("FAIL onehot: got %b required at most one bit set at %0t",
               {emergency, turn_right, turn_left}, $time);
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_mode(input string name, input logic [2:0] exp);
    checks++;
    if ({emergency, turn_right, turn_left} !== exp) begin
      fails++;
      $display("FAIL %s: got {e,r,l}=%b required %b at %0t",
               name, {emergency, turn_right, turn_left}, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_raw(input logic l, input logic r, input logic e);
    turn_left_raw  = l;
    turn_right_raw = r;
    emergency_raw  = e;
  endtask

  task automatic do_reset();
    set_raw(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    // Each entry: hold raw inputs for 'cycles' edges, then compare the mode.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 18, 3'b000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1,  3'b001};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 18, 3'b001};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1,  3'b100};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 18, 3'b100};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1,  3'b010};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 19, 3'b100};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 19, 3'b100};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 18, 3'b100};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1,  3'b001};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 19, 3'b000};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 19, 3'b100};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 19, 3'b000};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset with all switches on, then hazard after 19 edges.
    rst = 1'b1;
    set_raw(1'b1, 1'b1, 1'b1);
    step(1);
    check_mode("rst_cycle1_mode", 3'b000);
    check_bit("rst_cycle1_tick", step_tick, 1'b0);
    step(1);
    check_mode("rst_cycle2_mode", 3'b000);
    check_bit("rst_cycle2_tick", step_tick, 1'b0);
    rst = 1'b0;
    step(18);
    check_mode("rst_release_18", 3'b000);
    step(1);
    check_mode("rst_release_19", 3'b100);

    // Left turn latency and tick cadence after the mode change.
    do_reset();
    turn_left_raw = 1'b1;
    step(18);
    check_mode("left_18", 3'b000);
    step(1);
    check_mode("left_19", 3'b001);
    check_bit("left_tick_change", step_tick, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check_bit($sformatf("left_tick_%0d", k), step_tick, (k % 4) == 0);
    end

    // Short pulse and bouncing input are rejected; a clean hold is accepted.
    do_reset();
    saw = 1'b0;
    turn_right_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      saw |= turn_right;
    end
    turn_right_raw = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      saw |= turn_right;
    end
    for (int k = 0; k < 40; k++) begin
      turn_right_raw = pat[k % 5];
      step(1);
      saw |= turn_right;
    end
    turn_right_raw = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step(1);
      saw |= turn_right;
    end
    check_bit("right_reject", saw, 1'b0);
    step(1);
    check_mode("right_hold_19", 3'b010);

    // Both turns mean hazard; adding the hazard switch must not restart the tick.
    do_reset();
    set_raw(1'b1, 1'b1, 1'b0);
    step(18);
    check_mode("both_18", 3'b000);
    step(1);
    check_mode("both_19", 3'b100);
    emergency_raw = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      step(1);
      check_mode($sformatf("haz_hold_mode_%0d", k), 3'b100);
      check_bit($sformatf("haz_hold_tick_%0d", k), step_tick, (k % 4) == 0);
    end

    // Reset in mid-debounce discards the partial count.
    do_reset();
    turn_left_raw = 1'b1;
    step(11);
    rst = 1'b1;
    step(1);
    check_mode("midrst_mode", 3'b000);
    rst = 1'b0;
    step(18);
    check_mode("midrst_18", 3'b000);
    step(1);
    check_mode("midrst_19", 3'b001);

    // Left to right change landing on a would-be step edge.
    do_reset();
    turn_left_raw = 1'b1;
    step(19);
    check_mode("l2r_left", 3'b001);
    step(1);
    set_raw(1'b0, 1'b1, 1'b0);
    step(15);
    check_bit("l2r_tick_n16", step_tick, 1'b1);
    step(3);
    check_mode("l2r_n19_mode", 3'b001);
    step(1);
    check_mode("l2r_n20_mode", 3'b010);
    check_bit("l2r_n20_tick", step_tick, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check_bit($sformatf("l2r_tick_%0d", k), step_tick, k == 4);
    end

    // Table of mode transitions from idle.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_raw(tbl[i].l, tbl[i].r, tbl[i].e);
      step(tbl[i].cycles);
      check_mode($sformatf("tbl_%0d", i), tbl[i].exp_mode);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
